// File: rtl/fractal_render.sv
// fractal_render: column-major pixel scanner that feeds an external escape-time
// iteration engine one complex point at a time and plots the returned colour.
// rst_n is a synchronous reset that is asserted HIGH (the name is historical).
// Optional feature macro: FRACTAL_RENDER_BANDS_EN selects banded colouring of
// escaped pixels instead of the plain white/black default.
module fractal_render #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int MAX_ITER = 100,
    parameter int ITER_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic signed [31:0]  origin_a,
    input  logic signed [31:0]  origin_b,
    input  logic signed [31:0]  step_a,
    input  logic signed [31:0]  step_b,
    output logic                calc_en,
    output logic signed [31:0]  calc_a,
    output logic signed [31:0]  calc_b,
    input  logic                calc_ready,
    input  logic [ITER_W-1:0]   calc_iter,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [2:0]          vga_colour,
    output logic                vga_plot,
    output logic                done,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PLOT    = 3'd3,
        ADVANCE = 3'd4
    } state_t;

    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_RES - 1);
    localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);

    state_t              state, state_next;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic signed [31:0]  cur_a, cur_b;
    logic signed [31:0]  org_b, stp_a, stp_b;
    logic [ITER_W-1:0]   iter_q;
    logic                x_last, y_last;
    logic [2:0]          pix_colour;

    assign x_last = (x == X_LAST);
    assign y_last = (y == Y_LAST);

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst_n) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; abort outside IDLE overrides every other transition.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (calc_ready) state_next = PLOT;
            PLOT:    state_next = ADVANCE;
            ADVANCE: state_next = (x_last && y_last) ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
        if (abort && state != IDLE) state_next = IDLE;
    end

    // Scan counters, coordinate accumulators and the captured viewport.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            x      <= '0;
            y      <= '0;
            cur_a  <= '0;
            cur_b  <= '0;
            org_b  <= '0;
            stp_a  <= '0;
            stp_b  <= '0;
            iter_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x     <= '0;
                    y     <= '0;
                    cur_a <= origin_a;
                    cur_b <= origin_b;
                    org_b <= origin_b;
                    stp_a <= step_a;
                    stp_b <= step_b;
                end
                WAIT: if (calc_ready && !abort) iter_q <= calc_iter;
                ADVANCE: if (!abort) begin
                    if (!y_last) begin
                        y     <= y + 1'b1;
                        cur_b <= cur_b + stp_b;
                    end else if (!x_last) begin
                        y     <= '0;
                        cur_b <= org_b;
                        x     <= x + 1'b1;
                        cur_a <= cur_a + stp_a;
                    end
                end
                default: ;
            endcase
        end
    end

    // Colour of the pixel being plotted, from the latched iteration count.
    always_comb begin
        pix_colour = 3'b000;
`ifdef FRACTAL_RENDER_BANDS_EN
        if (iter_q < ITER_LIM)
            pix_colour = (iter_q[2:0] == 3'b000) ? 3'b001 : iter_q[2:0];
`else
        if (iter_q < ITER_LIM)
            pix_colour = 3'b111;
`endif
    end

    // Output decode; abort suppresses the pulses of the cycle it arrives in.
    always_comb begin
        done       = 1'b0;
        calc_en    = 1'b0;
        vga_plot   = 1'b0;
        frame_done = 1'b0;
        vga_colour = 3'b000;
        calc_a     = cur_a;
        calc_b     = cur_b;
        vga_x      = x;
        vga_y      = y;
        if (rst_n) begin
            done   = 1'b1;
            calc_a = '0;
            calc_b = '0;
            vga_x  = '0;
            vga_y  = '0;
        end else begin
            case (state)
                IDLE:    done = 1'b1;
                ISSUE:   calc_en = !abort;
                PLOT: begin
                    vga_plot   = !abort;
                    vga_colour = abort ? 3'b000 : pix_colour;
                end
                ADVANCE: frame_done = x_last && y_last && !abort;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fractal_render.sv
// tb_fractal_render: drives fractal_render on a 4x3 frame, plays the iteration
// engine itself and checks every launch and plot against a closed-form model
// (pixel k sits at column k/V, row k%V; point = origin + column*step_a, row*step_b).
module tb_fractal_render;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int NPIX = H * V;
    localparam int MAXI = 100;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, calc_ready;
    logic [31:0] origin_a, origin_b, step_a, step_b;
    logic        calc_en;
    logic [31:0] calc_a, calc_b;
    logic [15:0] calc_iter;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, done, frame_done;

    int errors = 0;
    int checks = 0;
    logic [31:0] vo_a, vo_b, vs_a, vs_b;
    int iter_plan[$];
    int pix_iter[NPIX];
    int plots, fdones;

    always #5 clk = ~clk;

    fractal_render #(
        .H_RES(H), .V_RES(V), .X_W(8), .Y_W(7), .MAX_ITER(MAXI), .ITER_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .origin_a(origin_a), .origin_b(origin_b), .step_a(step_a), .step_b(step_b),
        .calc_en(calc_en), .calc_a(calc_a), .calc_b(calc_b),
        .calc_ready(calc_ready), .calc_iter(calc_iter),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .done(done), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_colour(input int it);
`ifdef FRACTAL_RENDER_BANDS_EN
        if (it >= MAXI) return 3'b000;
        return (it % 8 == 0) ? 3'b001 : 3'(it % 8);
`else
        return (it < MAXI) ? 3'b111 : 3'b000;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},  32'(done), 1);
        check({tag, "_en"},    32'(calc_en), 0);
        check({tag, "_plot"},  32'(vga_plot), 0);
        check({tag, "_fd"},    32'(frame_done), 0);
        check({tag, "_col"},   32'(vga_colour), 0);
        check({tag, "_x"},     32'(vga_x), 0);
        check({tag, "_y"},     32'(vga_y), 0);
        check({tag, "_a"},     calc_a, 0);
        check({tag, "_b"},     calc_b, 0);
    endtask

    task automatic start_frame(input logic [31:0] oa, ob, sa, sb);
        @(negedge clk);
        origin_a = oa; origin_b = ob; step_a = sa; step_b = sb;
        vo_a = oa; vo_b = ob; vs_a = sa; vs_b = sb;
        start = 1'b1;
    endtask

    // lat: engine latency (-1 random); abort_pix: pixel aborted in WAIT (-1 none);
    // scramble: change the viewport inputs every cycle after the start cycle.
    task automatic run_frame(input int lat, input int abort_pix, input bit scramble);
        int pix = 0, wait_cnt = -1, last_en = -1, cyc = 0, abort_phase = 0;
        bit busy = 1'b1;
        logic [31:0] ea, eb;
        plots = 0;
        fdones = 0;
        while (busy) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (scramble) begin
                origin_a = $urandom; origin_b = $urandom;
                step_a = $urandom;   step_b = $urandom;
            end
            if (abort_phase < 2 && pix < NPIX) check("busy_done", 32'(done), 0);
            if (calc_en) begin
                ea = vo_a + 32'(pix / V) * vs_a;
                eb = vo_b + 32'(pix % V) * vs_b;
                check("calc_a", calc_a, ea);
                check("calc_b", calc_b, eb);
                if (lat == 0 && last_en >= 0) check("period", 32'(cyc - last_en), 4);
                last_en = cyc;
                pix_iter[pix] = (iter_plan.size() > 0) ? iter_plan.pop_front()
                                                       : int'($urandom_range(0, 130));
                wait_cnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
                if (pix == abort_pix) abort_phase = 1;
            end else if (abort_phase == 1) begin
                abort = 1'b1;
                abort_phase = 2;
            end else if (abort_phase == 2) begin
                check("abort_idle", 32'(done), 1);
                abort_phase = 3;
            end else if (abort_phase >= 3) begin
                abort_phase++;
                if (abort_phase > 12) busy = 1'b0;
            end
            if (abort_phase >= 2) begin
                check("abort_noplot", 32'(vga_plot), 0);
                check("abort_nofd", 32'(frame_done), 0);
                check("abort_noen", 32'(calc_en), 0);
            end
            if (abort_phase == 0 && wait_cnt == 0) begin
                calc_ready = 1'b1;
                calc_iter  = 16'(pix_iter[pix]);
                wait_cnt   = -1;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
            if (vga_plot) begin
                check("plot_x", 32'(vga_x), 32'(pix / V));
                check("plot_y", 32'(vga_y), 32'(pix % V));
                check("plot_col", 32'(vga_colour), 32'(exp_colour(pix_iter[pix])));
                pix++;
                plots++;
                calc_ready = 1'b0;
                calc_iter  = 16'($urandom);
            end else begin
                check("idle_col", 32'(vga_colour), 0);
            end
            if (frame_done) begin
                fdones++;
                check("fd_pix", 32'(pix), NPIX);
            end
            if (pix == NPIX && done) busy = 1'b0;
            if (cyc > 2000) begin
                check("timeout", 1, 0);
                busy = 1'b0;
            end
        end
    endtask

    initial begin
        bit seen;
        rst_n = 1'b1; start = 1'b1; abort = 1'b0; calc_ready = 1'b0; calc_iter = '0;
        origin_a = '0; origin_b = '0; step_a = '0; step_b = '0;

        // Reset state, with start held high during reset.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(done), 1);
        check("idle_en", 32'(calc_en), 0);

        // Reference frame: unit column step, half row step, engine latency 2.
        start_frame(32'h0, 32'h0, 32'h0001_0000, 32'h0000_8000);
        run_frame(2, -1, 1'b0);
        check("f1_plots", 32'(plots), NPIX);
        check("f1_fd", 32'(fdones), 1);
        check("f1_done", 32'(done), 1);

        // Colour thresholds, real-part wrap, viewport scrambling, 4-cycle pixels.
        iter_plan = '{99, 100, 8, 0, 7};
        start_frame(32'h7FFF_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0000_4000);
        run_frame(0, -1, 1'b1);
        check("f2_plots", 32'(plots), NPIX);
        check("f2_fd", 32'(fdones), 1);
        check("wrap_model", vo_a + vs_a, 32'h8001_0000);

        // Abort while waiting on pixel (1,1), then a clean full frame.
        start_frame($urandom, $urandom, $urandom, $urandom);
        run_frame(-1, 1 * V + 1, 1'b0);
        check("ab_plots", 32'(plots), 4);
        check("ab_fd", 32'(fdones), 0);
        check("ab_done", 32'(done), 1);
        start_frame($urandom, $urandom, $urandom, $urandom);
        run_frame(-1, -1, 1'b0);
        check("ab2_plots", 32'(plots), NPIX);
        check("ab2_fd", 32'(fdones), 1);

        // Reset asserted while a pixel is being plotted.
        start_frame(32'h1234_0000, 32'h0000_5678, 32'h0000_1000, 32'h0000_2000);
        calc_iter = 16'd3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            calc_ready = 1'b1;
            if (vga_plot) seen = 1'b1;
        end
        check("rp_seen", 32'(seen), 1);
        rst_n = 1'b1; start = 1'b1; calc_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("rp");
        @(negedge clk);
        check_reset_outputs("rp2");
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rp_idle", 32'(done), 1);
        check("rp_noen", 32'(calc_en), 0);

        // Random viewports and engine latencies.
        for (int f = 0; f < 3; f++) begin
            start_frame($urandom, $urandom, $urandom, $urandom);
            run_frame(-1, -1, 1'b1);
            check("rnd_plots", 32'(plots), NPIX);
            check("rnd_fd", 32'(fdones), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
